// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store stage: data word, access size and LSU state.
package base;

    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state;

    // Size code 3 falls through to the word case.
    function automatic logic [3:0] laneEnable(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SIZE_BYTE: laneEnable = 4'b0001 << off;
            SIZE_HALF: laneEnable = off[1] ? 4'b1100 : 4'b0011;
            default:   laneEnable = 4'b1111;
        endcase
    endfunction

    function automatic word laneReplicate(input logic [1:0] sz, input word sd);
        case (sz)
            SIZE_BYTE: laneReplicate = {4{sd[7:0]}};
            SIZE_HALF: laneReplicate = {2{sd[15:0]}};
            default:   laneReplicate = sd;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align_extend.sv
// Load lane select plus sign/zero extension of the returned memory word.
module load_align_extend
    import base::*;
(
    input  logic [31:0] memRData,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] loadData
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        case (offset)
            2'd0:    laneByte = memRData[7:0];
            2'd1:    laneByte = memRData[15:8];
            2'd2:    laneByte = memRData[23:16];
            default: laneByte = memRData[31:24];
        endcase
        laneHalf = offset[1] ? memRData[31:16] : memRData[15:0];

        case (size)
            SIZE_BYTE: loadData = {{24{~isUnsigned & laneByte[7]}}, laneByte};
            SIZE_HALF: loadData = {{16{~isUnsigned & laneHalf[15]}}, laneHalf};
            default:   loadData = memRData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one transaction per load/store, stalls until ack.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses via the misaligned output.
module load_store_unit
    import base::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isLoad,
    input  logic              isStore,
    input  logic [1:0]        size,
    input  logic              isUnsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] storeData,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic [3:0]        memByteEn,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck,
    output logic              stall,
    output logic              loadResultAvail,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic [DATA_W-1:0] loadData
);

    lsu_state          state;
    logic [1:0]        savedOff;
    logic [1:0]        savedSize;
    logic              savedUns;
    logic              savedLoad;
    logic [ADDR_W-1:0] savedAddr;
    logic              savedWe;
    logic [DATA_W-1:0] savedWData;
    logic [3:0]        savedBe;
    logic              access;
    logic [DATA_W-1:0] alignedData;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misAccess;
    assign misAccess  = ((size == SIZE_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign access     = (isLoad | isStore) & ~misAccess;
    assign misaligned = ~rst && (state == IDLE) && (isLoad | isStore) && misAccess;
`else
    assign access = isLoad | isStore;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            savedOff   <= '0;
            savedSize  <= '0;
            savedUns   <= 1'b0;
            savedLoad  <= 1'b0;
            savedAddr  <= '0;
            savedWe    <= 1'b0;
            savedWData <= '0;
            savedBe    <= '0;
        end else begin
            case (state)
                IDLE: if (access) begin
                    state      <= WAIT;
                    savedOff   <= addr[1:0];
                    savedSize  <= size;
                    savedUns   <= isUnsigned;
                    savedLoad  <= isLoad;
                    savedAddr  <= {addr[ADDR_W-1:2], 2'b00};
                    savedWe    <= isStore;
                    savedWData <= laneReplicate(size, storeData);
                    savedBe    <= laneEnable(size, addr[1:0]);
                end
                default: if (memAck) state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so an in-flight request drops in the reset cycle itself.
    always_comb begin
        memReq          = 1'b0;
        memWe           = 1'b0;
        memAddr         = '0;
        memWData        = '0;
        memByteEn       = '0;
        stall           = 1'b0;
        loadResultAvail = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                if (access) begin
                    memReq    = 1'b1;
                    memWe     = isStore;
                    memAddr   = {addr[ADDR_W-1:2], 2'b00};
                    memWData  = laneReplicate(size, storeData);
                    memByteEn = laneEnable(size, addr[1:0]);
                    stall     = 1'b1;
                end
            end else begin
                memReq          = 1'b1;
                memWe           = savedWe;
                memAddr         = savedAddr;
                memWData        = savedWData;
                memByteEn       = savedBe;
                stall           = ~memAck;
                loadResultAvail = memAck & savedLoad;
            end
        end
    end

    load_align_extend u_align (
        .memRData   (memRData),
        .offset     (savedOff),
        .size       (savedSize),
        .isUnsigned (savedUns),
        .loadData   (alignedData)
    );

    assign loadData = loadResultAvail ? alignedData : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed checking of load_store_unit against a transaction-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, isLoad, isStore, isUnsigned, memAck;
    logic [1:0]  size;
    logic [31:0] addr, storeData, memRData;
    logic        memReq, memWe, stall, loadResultAvail;
    logic [31:0] memAddr, memWData, loadData;
    logic [3:0]  memByteEn;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        eMis;
`endif

    logic        eReq, eWe, eStall, eLra;
    logic [31:0] eAddr, eWd, eLd;
    logic [3:0]  eBe;
    logic        chkEn = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .isLoad(isLoad), .isStore(isStore), .size(size),
        .isUnsigned(isUnsigned), .addr(addr), .storeData(storeData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memByteEn(memByteEn), .memRData(memRData), .memAck(memAck), .stall(stall),
        .loadResultAvail(loadResultAvail),
`ifdef LSU_MISALIGN_TRAP_EN
        .misaligned(misaligned),
`endif
        .loadData(loadData)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) if (chkEn) begin
        cmp("memReq", {31'b0, memReq}, {31'b0, eReq});
        cmp("memWe", {31'b0, memWe}, {31'b0, eWe});
        cmp("memAddr", memAddr, eAddr);
        cmp("memWData", memWData, eWd);
        cmp("memByteEn", {28'b0, memByteEn}, {28'b0, eBe});
        cmp("stall", {31'b0, stall}, {31'b0, eStall});
        cmp("loadResultAvail", {31'b0, loadResultAvail}, {31'b0, eLra});
        cmp("loadData", loadData, eLd);
`ifdef LSU_MISALIGN_TRAP_EN
        cmp("misaligned", {31'b0, misaligned}, {31'b0, eMis});
`endif
    end

    // Reference model: byte-enable, replicated write data and extended load value.
    function automatic logic [3:0] mBe(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] mWd(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return (sd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] mLd(input logic [1:0] sz, input logic uns,
                                        input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expIdle;
        eReq = 0; eWe = 0; eAddr = 0; eWd = 0; eBe = 0; eStall = 0; eLra = 0; eLd = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        eMis = 0;
`endif
    endtask

    task automatic idleCycle(input logic lateAck);
        isLoad = 0; isStore = 0;
        size = 2'($urandom); isUnsigned = 1'($urandom);
        addr = $urandom; storeData = $urandom; memRData = $urandom;
        memAck = lateAck;
        expIdle();
        tick();
    endtask

    task automatic doAccess(input logic ld, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                            input int lat, input logic useLit, input logic [31:0] litAddr,
                            input logic [3:0] litBe, input logic [31:0] litWd,
                            input logic [31:0] litLd);
        logic [31:0] xAddr, xWd, xLd;
        logic [3:0]  xBe;
        xAddr = useLit ? litAddr : (a & 32'hFFFFFFFC);
        xBe   = useLit ? litBe   : mBe(sz, a);
        xWd   = useLit ? litWd   : mWd(sz, sd);
        xLd   = useLit ? litLd   : (ld ? mLd(sz, uns, a, rd) : 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00)) begin
            isLoad = ld; isStore = !ld; size = sz; isUnsigned = uns;
            addr = a; storeData = sd; memAck = 0; memRData = $urandom;
            expIdle();
            eMis = 1;
            tick();
            return;
        end
`endif
        for (int c = 0; c <= lat; c++) begin
            isLoad = ld; isStore = !ld;
            if (c == 0) begin
                size = sz; isUnsigned = uns; addr = a; storeData = sd;
            end else begin
                // Registered request fields must not follow the inputs once issued.
                size = 2'($urandom); isUnsigned = 1'($urandom);
                addr = $urandom; storeData = $urandom;
            end
            memAck   = (c == lat);
            memRData = (c == lat) ? rd : $urandom;
            expIdle();
            eReq = 1; eWe = !ld; eAddr = xAddr; eWd = xWd; eBe = xBe;
            eStall = (c != lat);
            eLra = (c == lat) && ld;
            eLd  = eLra ? xLd : 32'h0;
            tick();
        end
    endtask

    initial begin
        rst = 1; isLoad = 0; isStore = 0; size = 0; isUnsigned = 0;
        addr = 0; storeData = 0; memRData = 0; memAck = 0;
        expIdle();
        #1;
        chkEn = 1;
        tick(); tick();
        rst = 0;
        idleCycle(0);

        doAccess(1, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
        idleCycle(0);
        doAccess(1, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 1, 1, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80);
        doAccess(1, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 2, 1, 32'h100, 4'h8, 32'h0, 32'h00000080);
        idleCycle(1);
        doAccess(0, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h55AA55AA, 3, 1, 32'h200, 4'hC, 32'hABCDABCD, 32'h0);
        idleCycle(0);

        // Reset in the second WAIT cycle, late ack afterwards.
        isLoad = 1; isStore = 0; size = 2'd2; isUnsigned = 0; addr = 32'h300; storeData = 0;
        memAck = 0; memRData = 0;
        expIdle(); eReq = 1; eAddr = 32'h300; eBe = 4'hF; eStall = 1;
        tick();
        tick();
        rst = 1;
        expIdle();
        tick();
        rst = 0; isLoad = 0; memAck = 1; memRData = 32'h12345678;
        tick();
        idleCycle(0);
        idleCycle(0);

        doAccess(1, 2'd2, 0, 32'h10, 32'h0, 32'hCAFEF00D, 1, 1, 32'h10, 4'hF, 32'h0, 32'hCAFEF00D);
        doAccess(0, 2'd2, 0, 32'h14, 32'h87654321, 32'h0, 1, 1, 32'h14, 4'hF, 32'h87654321, 32'h0);
        idleCycle(0);

`ifdef LSU_MISALIGN_TRAP_EN
        doAccess(1, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h0);
`else
        doAccess(1, 2'd2, 0, 32'h102, 32'h0, 32'h0BADF00D, 1, 1, 32'h100, 4'hF, 32'h0, 32'h0BADF00D);
`endif
        idleCycle(0);

        for (int i = 0; i < 200; i++) begin
            logic        ld;
            logic [1:0]  sz;
            logic [31:0] a;
            ld = 1'($urandom);
            sz = 2'($urandom);
            a  = 32'h1000 + ($urandom % 64);
            doAccess(ld, sz, 1'($urandom), a, $urandom, $urandom, 1 + ($urandom % 4),
                     0, 32'h0, 4'h0, 32'h0, 32'h0);
            for (int k = 0; k < int'($urandom % 3); k++) idleCycle(1'($urandom));
        end

        idleCycle(0);
        chkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
